// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program counter: next-pc select codes and
// the RAS pointer-width helper.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_RET,
    SEL_HOLD
  } pc_sel_t;

  // Pointer width for a RAS of the given depth; never narrower than one bit.
  function automatic int ras_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Redirect inputs and pc/link outputs between the fetch control and pc_unit.
interface pc_unit_if #(
  parameter int W = 32
);
  logic         stall;
  logic         br_taken;
  logic [W-1:0] br_target;
  logic         jump;
  logic         call;
  logic         ret;
  logic [W-1:0] jmp_target;
  logic [W-1:0] pc;
  logic [W-1:0] pc_plus;
  logic         ras_ovf;
  logic         ras_unf;

  modport master (
    output stall, br_taken, br_target, jump, call, ret, jmp_target,
    input  pc, pc_plus, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, br_taken, br_target, jump, call, ret, jmp_target,
    output pc, pc_plus, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push past full overwrites the oldest entry.
// Pop on an empty stack is ignored; top is the entry below the write pointer.
module pc_ras
  import pc_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = ras_ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_idx;
  logic [CW-1:0] cnt;
  logic          do_pop;
  logic          do_push;

  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !do_pop;

  // When full, ptr already sits on the oldest slot, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr <= '0;
      cnt <= '0;
    end else if (do_pop) begin
      ptr <= top_idx;
      cnt <= cnt - CW'(1);
    end else if (do_push) begin
      ptr <= ptr + PW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[ptr] <= push_dat;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, branch, jump and call/return redirects.
// Define PC_RAS_EN to build the return-address stack and its sticky ovf/unf flags.
module pc_unit
  import pc_pkg::*;
#(
  parameter int          W         = 32,
  parameter int unsigned STEP      = 1,
  parameter logic [W-1:0] RESET_VEC = '0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic      clk,
  input  logic      clr,
  pc_unit_if.slave  bus
);

  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [W-1:0] pc_q;
  logic [W-1:0] pc_plus_q;
  logic [W-1:0] pc_nxt;
  logic [W-1:0] ras_top;
  logic         ras_push;
  logic         ras_pop;
  logic         ras_full;
  logic         ras_empty;
  logic         set_ovf;
  logic         set_unf;
  logic         ovf_q;
  logic         unf_q;
  pc_sel_t      sel;

  // Ret outranks call/jump; with nothing to pop it falls back to sequential.
  always_comb begin
    sel      = SEL_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (bus.stall) begin
      sel = SEL_HOLD;
    end else if (bus.ret) begin
      if (!ras_empty) begin
        sel     = SEL_RET;
        ras_pop = 1'b1;
      end else begin
        set_unf = 1'b1;
      end
    end else if (bus.call || bus.jump) begin
      sel      = SEL_JMP;
      ras_push = bus.call;
      set_ovf  = bus.call && ras_full;
    end else if (bus.br_taken) begin
      sel = SEL_BR;
    end
  end

  // pc_plus_q already holds pc + STEP, so the sequential path needs no adder.
  always_comb begin
    pc_nxt = pc_plus_q;
    unique case (sel)
      SEL_BR:   pc_nxt = bus.br_target;
      SEL_JMP:  pc_nxt = bus.jmp_target;
      SEL_RET:  pc_nxt = ras_top;
      SEL_HOLD: pc_nxt = pc_q;
      default:  pc_nxt = pc_plus_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q      <= RESET_VEC;
      pc_plus_q <= RESET_VEC + STEP_W;
    end else begin
      pc_q      <= pc_nxt;
      pc_plus_q <= pc_nxt + STEP_W;
    end
  end

`ifdef PC_RAS_EN
  pc_ras #(
    .W     (W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .clr      (clr),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_dat (pc_plus_q),
    .top      (ras_top),
    .full     (ras_full),
    .empty    (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
    end
  end
`else
  // Without a stack every ret sees "empty" and call degenerates to jump.
  logic unused_ras;
  assign ras_top    = '0;
  assign ras_full   = 1'b0;
  assign ras_empty  = 1'b1;
  assign ovf_q      = 1'b0;
  assign unf_q      = 1'b0;
  assign unused_ras = ^{ras_push, ras_pop, set_ovf, set_unf, (RAS_DEPTH > 0)};
`endif

  assign bus.pc      = pc_q;
  assign bus.pc_plus = pc_plus_q;
  assign bus.ras_ovf = ovf_q;
  assign bus.ras_unf = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios then random redirects against a queue-based model.
module tb_pc_unit;

`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int RAS_DEPTH = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  pc_unit_if #(.W(32)) bus ();
  pc_unit_if #(.W(8))  wbus ();

  pc_unit #(.W(32), .STEP(1), .RESET_VEC(32'h0), .RAS_DEPTH(RAS_DEPTH)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  pc_unit #(.W(8), .STEP(4), .RESET_VEC(8'hF8), .RAS_DEPTH(2)) u_wrap (
    .clk (clk),
    .clr (clr),
    .bus (wbus)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras [$];
  logic        m_ovf;
  logic        m_unf;
  logic [7:0]  w_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic c, input logic s, input logic r, input logic ca,
                      input logic j, input logic b, input logic [31:0] bt,
                      input logic [31:0] jt);
    logic [31:0] popped;
    clr            = c;
    bus.stall      = s;
    bus.ret        = r;
    bus.call       = ca;
    bus.jump       = j;
    bus.br_taken   = b;
    bus.br_target  = bt;
    bus.jmp_target = jt;
    @(posedge clk);
    if (c) begin
      m_pc  = 32'h0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      w_pc  = 8'hF8;
    end else begin
      w_pc = w_pc + 8'd4;
      if (!s) begin
        if (r) begin
          if (RAS_EN && m_ras.size() > 0) begin
            popped = m_ras.pop_back();
            m_pc   = popped;
          end else begin
            m_pc = m_pc + 32'd1;
            if (RAS_EN) m_unf = 1'b1;
          end
        end else if (ca || j) begin
          if (ca && RAS_EN) begin
            if (m_ras.size() == RAS_DEPTH) begin
              popped = m_ras.pop_front();
              m_ovf  = 1'b1;
            end
            m_ras.push_back(m_pc + 32'd1);
          end
          m_pc = jt;
        end else if (b) begin
          m_pc = bt;
        end else begin
          m_pc = m_pc + 32'd1;
        end
      end
    end
    #1;
    chk("pc", bus.pc, m_pc);
    chk("pc_plus", bus.pc_plus, m_pc + 32'd1);
    chk("ras_ovf", {31'b0, bus.ras_ovf}, {31'b0, m_ovf});
    chk("ras_unf", {31'b0, bus.ras_unf}, {31'b0, m_unf});
    chk("wrap_pc", {24'b0, wbus.pc}, {24'b0, w_pc});
    chk("wrap_plus", {24'b0, wbus.pc_plus}, {24'b0, w_pc + 8'd4});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic c, s, r, ca, j, b;
    logic [31:0] bt, jt;
    clr = 1'b1;
    bus.stall = 1'b0; bus.ret = 1'b0; bus.call = 1'b0; bus.jump = 1'b0;
    bus.br_taken = 1'b0; bus.br_target = '0; bus.jmp_target = '0;
    wbus.stall = 1'b0; wbus.ret = 1'b0; wbus.call = 1'b0; wbus.jump = 1'b0;
    wbus.br_taken = 1'b0; wbus.br_target = '0; wbus.jmp_target = '0;

    // Reset then sequential increment; narrow instance exercises wrap-around.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_plus", bus.pc_plus, 32'h1);
    chk("wrap_rst", {24'b0, wbus.pc}, 32'hF8);
    idle();
    chk("wrap_fc", {24'b0, wbus.pc}, 32'hFC);
    chk("wrap_plus_fc", {24'b0, wbus.pc_plus}, 32'h00);
    idle();
    chk("wrap_00", {24'b0, wbus.pc}, 32'h00);
    idle();
    chk("inc_pc", bus.pc, 32'h3);
    chk("inc_plus", bus.pc_plus, 32'h4);
    idle();
    idle();
    chk("at5", bus.pc, 32'h5);

    // Stall masks a jump until released.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40);
      chk("stall_hold", bus.pc, 32'h5);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40);
    chk("stall_release", bus.pc, 32'h40);

    // Priority: ret over jump over branch.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0F, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h50);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h30, 32'h20);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h30, 32'h20);
    chk("prio_jmp", bus.pc, 32'h20);

    // Nested call/return.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h100);
    chk("call1", bus.pc, 32'h100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200);
    chk("call2", bus.pc, 32'h200);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Overflow and underflow, then clear.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h300 + 32'(i) * 32'h10);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("clr_ovf", {31'b0, bus.ras_ovf}, 32'h0);
    chk("clr_unf", {31'b0, bus.ras_unf}, 32'h0);
    chk("clr_pc", bus.pc, 32'h0);

    // Random redirects, including targets near the top of the address space.
    for (int n = 0; n < 3000; n++) begin
      c  = ($urandom_range(63) == 0);
      s  = ($urandom_range(7) == 0);
      r  = ($urandom_range(5) == 0);
      ca = ($urandom_range(3) == 0);
      j  = ($urandom_range(9) == 0);
      b  = ($urandom_range(4) == 0);
      bt = ($urandom_range(3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(3))) : $urandom;
      jt = ($urandom_range(3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(3))) : $urandom;
      step(c, s, r, ca, j, b, bt, jt);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
